freq_table_ramp: RTL and testbench

FREQ_TABLE_RAMP -- requirements
Module: freq_table_ramp

---
 rtl/freq_table_ramp_pkg.sv | 29 ++
 rtl/freq_slew_step.sv | 30 +++
 rtl/freq_table_ramp.sv | 122 ++++++++++++
 tb/tb_freq_table_ramp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_table_ramp_pkg.sv
// Shared types and table defaults for the frequency table ramp.
// Default table, state encoding and code clamping helper.
package freq_table_ramp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_ABOVE = 200;
    localparam int DEF_TABLE [DEF_DEPTH] = '{
        30, 50, 75, 100, 125, 150, 175, 200
    };

    function automatic int clamp_code(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int table_default(input int idx, input int w);
        int v;
        if (idx >= 0 && idx < DEF_DEPTH) v = DEF_TABLE[idx[2:0]];
        else v = DEF_ABOVE;
        return clamp_code(v, w);
    endfunction

endpackage

// File: rtl/freq_slew_step.sv
// Combinational slew limiter: moves cur toward tgt by at most STEP.
// Never overshoots the target and never wraps the code range.
module freq_slew_step #(
    parameter int CODE_W = 8,
    parameter int STEP   = 5
) (
    input  logic [CODE_W-1:0] cur_i,
    input  logic [CODE_W-1:0] tgt_i,
    output logic [CODE_W-1:0] nxt_o,
    output logic              eq_o
);

    localparam logic [CODE_W-1:0] STEP_C = CODE_W'(STEP);

    logic [CODE_W-1:0] diff;

    always_comb begin
        nxt_o = cur_i;
        diff  = '0;
        eq_o  = (cur_i == tgt_i);
        if (tgt_i > cur_i) begin
            diff  = tgt_i - cur_i;
            nxt_o = (diff > STEP_C) ? cur_i + STEP_C : tgt_i;
        end else if (cur_i > tgt_i) begin
            diff  = cur_i - tgt_i;
            nxt_o = (diff > STEP_C) ? cur_i - STEP_C : tgt_i;
        end
    end

endmodule

// File: rtl/freq_table_ramp.sv
// Table-driven frequency code ramp with slew-limited retargeting.
// FREQ_TABLE_WR_EN turns the constant table into a writable register file.
module freq_table_ramp
    import freq_table_ramp_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int CODE_W   = 8,
    parameter int STEP     = 5,
    parameter int TICK_DIV = 1000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [SEL_W-1:0]  num_frecuencia,
    input  logic              load,
`ifdef FREQ_TABLE_WR_EN
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_addr,
    input  logic [CODE_W-1:0] wr_data,
`endif
    output logic [CODE_W-1:0] frecuencia,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** SEL_W;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] freq_q, freq_d;
    logic [CODE_W-1:0] target_q, target_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic              done_q, done_d;

    logic [CODE_W-1:0] tbl;
    logic [CODE_W-1:0] tgt_eff;
    logic [CODE_W-1:0] step_nxt;
    logic              at_tgt;

`ifdef FREQ_TABLE_WR_EN
    logic [CODE_W-1:0] table_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++)
                table_q[i] <= CODE_W'(table_default(i, CODE_W));
        end else if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read sees the pre-write value on a same-cycle write.
    assign tbl = table_q[num_frecuencia];
`else
    assign tbl = CODE_W'(table_default(int'(num_frecuencia), CODE_W));
`endif

    assign tgt_eff = load ? tbl : target_q;

    freq_slew_step #(
        .CODE_W (CODE_W),
        .STEP   (STEP)
    ) u_slew (
        .cur_i  (freq_q),
        .tgt_i  (tgt_eff),
        .nxt_o  (step_nxt),
        .eq_o   (at_tgt)
    );

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        target_d = target_q;
        tick_d   = '0;
        done_d   = 1'b0;
        if (load) target_d = tbl;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (at_tgt) done_d = 1'b1;
                    else state_d = RAMP;
                end
            end
            RAMP: begin
                if (at_tgt) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick_q == TICK_LAST) begin
                    freq_d = step_nxt;
                    if (step_nxt == tgt_eff) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            target_q <= '0;
            tick_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            target_q <= target_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign frecuencia = freq_q;
    assign busy       = (state_q == RAMP);
    assign done       = done_q;

endmodule

// File: tb/tb_freq_table_ramp.sv
// Directed bench for freq_table_ramp (TICK_DIV=4, STEP=5, CODE_W=8).
// Define FREQ_TABLE_WR_EN to also exercise the writable table.
module tb_freq_table_ramp;

    localparam int SEL_W    = 3;
    localparam int CODE_W   = 8;
    localparam int STEP     = 5;
    localparam int TICK_DIV = 4;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [SEL_W-1:0]  num_frecuencia = '0;
    logic              load = 1'b0;
    logic [CODE_W-1:0] frecuencia;
    logic              busy;
    logic              done;
`ifdef FREQ_TABLE_WR_EN
    logic              wr_en = 1'b0;
    logic [SEL_W-1:0]  wr_addr = '0;
    logic [CODE_W-1:0] wr_data = '0;
`endif

    int tests = 0;
    int fails = 0;

    freq_table_ramp #(
        .SEL_W    (SEL_W),
        .CODE_W   (CODE_W),
        .STEP     (STEP),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .num_frecuencia (num_frecuencia),
        .load           (load),
`ifdef FREQ_TABLE_WR_EN
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
`endif
        .frecuencia     (frecuencia),
        .busy           (busy),
        .done           (done)
    );

    always #5 CLK = ~CLK;

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        load = 1'b1;
        num_frecuencia = 3'd7;
        clk1();
        clk1();
        tests++;
        if (frecuencia !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state f=%0d busy=%b done=%b want 0/0/0",
                     frecuencia, busy, done);
        end
        RESET = 1'b0;
        load = 1'b0;
        clk1();
        tests++;
        if (frecuencia !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_load_ignored f=%0d busy=%b done=%b want 0/0/0",
                     frecuencia, busy, done);
        end
    endtask

    task automatic test_first_ramp();
        int ef, nb, nd;
        logic eb, ed;
        nb = 0;
        nd = 0;
        num_frecuencia = 3'd0;
        load = 1'b1;
        clk1();
        load = 1'b0;
        for (int c = 0; c <= 26; c++) begin
            if (c > 0) clk1();
            ef = 5 * (c / 4);
            if (ef > 30) ef = 30;
            eb = (c < 24);
            ed = (c == 24);
            nb += busy;
            nd += done;
            tests++;
            if (frecuencia !== ef[7:0] || busy !== eb || done !== ed) begin
                fails++;
                $display("FAIL first_ramp c=%0d f=%0d b=%b d=%b want %0d/%b/%b",
                         c, frecuencia, busy, done, ef, eb, ed);
            end
        end
        tests++;
        if (nb != 24 || nd != 1) begin
            fails++;
            $display("FAIL first_ramp_counts busy=%0d done=%0d want 24/1",
                     nb, nd);
        end
    endtask

    task automatic test_ramp_up();
        int ef, nd;
        logic eb, ed;
        nd = 0;
        num_frecuencia = 3'b111;
        load = 1'b1;
        clk1();
        load = 1'b0;
        for (int c = 0; c <= 138; c++) begin
            if (c > 0) clk1();
            ef = 30 + 5 * (c / 4);
            if (ef > 200) ef = 200;
            eb = (c < 136);
            ed = (c == 136);
            nd += done;
            tests++;
            if (frecuencia !== ef[7:0] || busy !== eb || done !== ed) begin
                fails++;
                $display("FAIL ramp_up c=%0d f=%0d b=%b d=%b want %0d/%b/%b",
                         c, frecuencia, busy, done, ef, eb, ed);
            end
        end
        tests++;
        if (nd != 1) begin
            fails++;
            $display("FAIL ramp_up_done_count got=%0d want 1", nd);
        end
    endtask

    task automatic test_retarget();
        int ef;
        logic eb, ed;
        num_frecuencia = 3'b000;
        load = 1'b1;
        clk1();
        load = 1'b0;
        for (int c = 0; c <= 82; c++) begin
            if (c > 0) clk1();
            if (c == 41) load = 1'b0;
            ef = 200 - 5 * (c / 4);
            if (ef < 100) ef = 100;
            eb = (c < 80);
            ed = (c == 80);
            tests++;
            if (frecuencia !== ef[7:0] || busy !== eb || done !== ed) begin
                fails++;
                $display("FAIL retarget c=%0d f=%0d b=%b d=%b want %0d/%b/%b",
                         c, frecuencia, busy, done, ef, eb, ed);
            end
            if (c == 40) begin
                num_frecuencia = 3'b011;
                load = 1'b1;
            end
        end
    endtask

    task automatic test_equal_load();
        num_frecuencia = 3'b011;
        load = 1'b1;
        clk1();
        load = 1'b0;
        tests++;
        if (frecuencia !== 8'd100 || busy !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL equal_load f=%0d b=%b d=%b want 100/0/1",
                     frecuencia, busy, done);
        end
        clk1();
        tests++;
        if (frecuencia !== 8'd100 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL equal_load_after f=%0d b=%b d=%b want 100/0/0",
                     frecuencia, busy, done);
        end
    endtask

    task automatic test_reset_mid_ramp();
        int ef;
        num_frecuencia = 3'b000;
        load = 1'b1;
        clk1();
        load = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) clk1();
            ef = 100 - 5 * (c / 4);
            tests++;
            if (frecuencia !== ef[7:0] || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL pre_reset c=%0d f=%0d b=%b d=%b want %0d/1/0",
                         c, frecuencia, busy, done, ef);
            end
        end
        RESET = 1'b1;
        clk1();
        tests++;
        if (frecuencia !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset f=%0d b=%b d=%b want 0/0/0",
                     frecuencia, busy, done);
        end
        RESET = 1'b0;
        for (int c = 0; c < 8; c++) begin
            clk1();
            tests++;
            if (frecuencia !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL post_reset c=%0d f=%0d b=%b d=%b want 0/0/0",
                         c, frecuencia, busy, done);
            end
        end
    endtask

`ifdef FREQ_TABLE_WR_EN
    task automatic test_table_write();
        int ef;
        logic eb, ed;
        wr_en = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'd90;
        num_frecuencia = 3'd2;
        load = 1'b1;
        clk1();
        wr_en = 1'b0;
        load = 1'b0;
        for (int c = 0; c <= 64; c++) begin
            if (c > 0) clk1();
            ef = 5 * (c / 4);
            if (ef > 75) ef = 75;
            eb = (c < 60);
            ed = (c == 60);
            tests++;
            if (frecuencia !== ef[7:0] || busy !== eb || done !== ed) begin
                fails++;
                $display("FAIL wr_old c=%0d f=%0d b=%b d=%b want %0d/%b/%b",
                         c, frecuencia, busy, done, ef, eb, ed);
            end
        end
        load = 1'b1;
        clk1();
        load = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) clk1();
            ef = 75 + 5 * (c / 4);
            if (ef > 90) ef = 90;
            eb = (c < 12);
            ed = (c == 12);
            tests++;
            if (frecuencia !== ef[7:0] || busy !== eb || done !== ed) begin
                fails++;
                $display("FAIL wr_new c=%0d f=%0d b=%b d=%b want %0d/%b/%b",
                         c, frecuencia, busy, done, ef, eb, ed);
            end
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_first_ramp();
        test_ramp_up();
        test_retarget();
        test_equal_load();
        test_reset_mid_ramp();
`ifdef FREQ_TABLE_WR_EN
        test_table_write();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
